// File: rtl/muldiv_if.sv
// Handshake and result bundle between a requester and the iterative multiply/divide unit.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             hi_lo_write;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;

    modport master (
        output start, op, a, b,
        input  busy, done, hi_lo_write, hi_out, lo_out
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, hi_lo_write, hi_out, lo_out
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO register pair.
// One bit per cycle on operand magnitudes, followed by a single sign-fix cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   cnt;
    logic [1:0]         op_q;
    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   hi_q, lo_q;

    logic               in_signed, in_div, div_zero;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH:0]   mul_ext;
    logic [2*WIDTH:0]   div_sh;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_nx;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix, rem_fix;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic is_signed);
        logic signed [WIDTH-1:0] s;
        s = signed'(v);
        // The most negative value maps onto itself and is then read as unsigned.
        return (is_signed && s < 0) ? unsigned'(-s) : v;
    endfunction

    function automatic logic [WIDTH-1:0] negate_w(input logic [WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] negate_2w(input logic [2*WIDTH-1:0] v, input logic n);
        return n ? (~v + 1'b1) : v;
    endfunction

    assign in_signed = ~bus.op[0];
    assign in_div    = bus.op[1];
    assign div_zero  = in_div && (bus.b == '0);

    // Shift-add step: upper half plus carry absorbs the multiplicand, then everything shifts right.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
    assign mul_ext  = acc[0] ? {mul_sum, acc[WIDTH-1:0]} : {1'b0, acc};

    // Restoring step: {rem, quot} shifted left, keep the trial difference when it stays non-negative.
    assign div_sh   = {acc, 1'b0};
    assign div_diff = div_sh[2*WIDTH:WIDTH] - {1'b0, opnd};

    always_comb begin
        step_nx = mul_ext[2*WIDTH:1];
        if (op_q[1]) begin
            step_nx = div_diff[WIDTH] ? div_sh[2*WIDTH-1:0]
                                      : {div_diff[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1};
        end
    end

    assign prod_fix = negate_2w(acc, (neg_a ^ neg_b) && op_q == 2'b00);
    assign quot_fix = negate_w(acc[WIDTH-1:0], (neg_a ^ neg_b) && op_q == 2'b10);
    assign rem_fix  = negate_w(acc[2*WIDTH-1:WIDTH], neg_a && op_q == 2'b10);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (bus.start) state_nx = div_zero ? DONE : CALC;
            CALC: if (cnt == CNT_W'(WIDTH - 1)) state_nx = FIX;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state != IDLE);
        bus.done        = (state == DONE);
        bus.hi_lo_write = (state == DONE);
        bus.hi_out      = hi_q;
        bus.lo_out      = lo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            op_q  <= '0;
            neg_a <= 1'b0;
            neg_b <= 1'b0;
            opnd  <= '0;
            acc   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_q  <= bus.op;
                    neg_a <= in_signed && bus.a[WIDTH-1];
                    neg_b <= in_signed && bus.b[WIDTH-1];
                    cnt   <= '0;
                    if (in_div) begin
                        acc  <= {{WIDTH{1'b0}}, magnitude(bus.a, in_signed)};
                        opnd <= magnitude(bus.b, in_signed);
                    end else begin
                        acc  <= {{WIDTH{1'b0}}, magnitude(bus.b, in_signed)};
                        opnd <= magnitude(bus.a, in_signed);
                    end
                    if (div_zero) begin
                        hi_q <= bus.a;
                        lo_q <= '1;
                    end
                end
                CALC: begin
                    acc <= step_nx;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    if (op_q[1]) begin
                        hi_q <= rem_fix;
                        lo_q <= quot_fix;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    muldiv_if #(.WIDTH(W)) bus ();
    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request, let one edge sample it, then withdraw start.
    task automatic start_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op = op;
        bus.a = a;
        bus.b = b;
        step();
        bus.start = 1'b0;
    endtask

    // Edges after the start edge until done is visible (60 means it never came).
    task automatic wait_done(output int cyc, output bit busy_dropped);
        cyc = 0;
        busy_dropped = 0;
        if (bus.busy !== 1'b1) busy_dropped = 1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            step();
            cyc++;
            if (bus.busy !== 1'b1) busy_dropped = 1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
        step(); step();
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        n_chk++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b want 0", bus.done); end
        n_chk++; if (bus.hi_lo_write !== 1'b0) begin n_fail++; $display("FAIL reset_hlw got %0b want 0", bus.hi_lo_write); end
        n_chk++; if (bus.hi_out !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", bus.hi_out); end
        n_chk++; if (bus.lo_out !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", bus.lo_out); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_multu_max();
        int cyc; bit bd;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL multu_latency got %0d want 33", cyc); end
        n_chk++; if (bd) begin n_fail++; $display("FAIL multu_busy got dropped want held"); end
        n_chk++; if (bus.hi_lo_write !== 1'b1) begin n_fail++; $display("FAIL multu_hlw got %0b want 1", bus.hi_lo_write); end
        n_chk++; if (bus.hi_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", bus.hi_out); end
        n_chk++; if (bus.lo_out !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", bus.lo_out); end
        step();
        n_chk++; if (bus.done !== 1'b0 || bus.hi_lo_write !== 1'b0) begin n_fail++; $display("FAIL multu_pulse got done=%0b hlw=%0b want 0 0", bus.done, bus.hi_lo_write); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL multu_idle_busy got %0b want 0", bus.busy); end
        n_chk++; if (bus.hi_out !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hold_hi got %h want fffffffe", bus.hi_out); end
    endtask

    task automatic test_mult_signed();
        int cyc; bit bd;
        start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL mult_neg_latency got %0d want 33", cyc); end
        n_chk++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_neg_hi got %h want ffffffff", bus.hi_out); end
        n_chk++; if (bus.lo_out !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_neg_lo got %h want fffffff1", bus.lo_out); end
        step();
        start_op(2'b00, 32'd7, 32'd6);
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL mult_pos_latency got %0d want 33", cyc); end
        n_chk++; if (bus.hi_out !== 32'h0) begin n_fail++; $display("FAIL mult_pos_hi got %h want 0", bus.hi_out); end
        n_chk++; if (bus.lo_out !== 32'h2A) begin n_fail++; $display("FAIL mult_pos_lo got %h want 0000002a", bus.lo_out); end
        step();
    endtask

    task automatic test_div();
        int cyc; bit bd;
        start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL div_neg_latency got %0d want 33", cyc); end
        n_chk++; if (bus.lo_out !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_quot got %h want fffffffd", bus.lo_out); end
        n_chk++; if (bus.hi_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_rem got %h want ffffffff", bus.hi_out); end
        step();
        start_op(2'b11, 32'd100, 32'd7);
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL divu_latency got %0d want 33", cyc); end
        n_chk++; if (bus.lo_out !== 32'd14) begin n_fail++; $display("FAIL divu_quot got %0d want 14", bus.lo_out); end
        n_chk++; if (bus.hi_out !== 32'd2) begin n_fail++; $display("FAIL divu_rem got %0d want 2", bus.hi_out); end
        step();
    endtask

    task automatic test_div_edge();
        int cyc; bit bd;
        start_op(2'b11, 32'h64, 32'h0);
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 0) begin n_fail++; $display("FAIL divzero_latency got %0d want 0", cyc); end
        n_chk++; if (bus.hi_out !== 32'h64) begin n_fail++; $display("FAIL divzero_hi got %h want 00000064", bus.hi_out); end
        n_chk++; if (bus.lo_out !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divzero_lo got %h want ffffffff", bus.lo_out); end
        step();
        n_chk++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL divzero_after got busy=%0b done=%0b want 0 0", bus.busy, bus.done); end
        start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL divovf_latency got %0d want 33", cyc); end
        n_chk++; if (bus.lo_out !== 32'h8000_0000) begin n_fail++; $display("FAIL divovf_quot got %h want 80000000", bus.lo_out); end
        n_chk++; if (bus.hi_out !== 32'h0) begin n_fail++; $display("FAIL divovf_rem got %h want 0", bus.hi_out); end
        step();
    endtask

    task automatic test_busy_ignore();
        int done_cnt = 0;
        int first_done = -1;
        start_op(2'b01, 32'd3, 32'd4);
        for (int c = 1; c <= 45; c++) begin
            if (c == 5) begin bus.start = 1'b1; bus.op = 2'b10; bus.a = 32'd9; bus.b = 32'd3; end
            if (c == 6) bus.start = 1'b0;
            if (c == 10) begin bus.a = 32'd55; bus.b = 32'd77; end
            step();
            if (bus.done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) begin
                    first_done = c;
                    n_chk++; if (bus.lo_out !== 32'd12) begin n_fail++; $display("FAIL ignore_lo got %0d want 12", bus.lo_out); end
                    n_chk++; if (bus.hi_out !== 32'd0) begin n_fail++; $display("FAIL ignore_hi got %0d want 0", bus.hi_out); end
                end
            end
        end
        n_chk++; if (first_done !== 33) begin n_fail++; $display("FAIL ignore_latency got %0d want 33", first_done); end
        n_chk++; if (done_cnt !== 1) begin n_fail++; $display("FAIL ignore_done_count got %0d want 1", done_cnt); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL ignore_not_queued got busy=%0b want 0", bus.busy); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit bd;
        start_op(2'b01, 32'd5, 32'd5);
        wait_done(cyc, bd);
        n_chk++; if (bus.lo_out !== 32'd25) begin n_fail++; $display("FAIL b2b_first_lo got %0d want 25", bus.lo_out); end
        // Request presented during the DONE cycle must only be taken once back in IDLE.
        bus.start = 1'b1; bus.op = 2'b11; bus.a = 32'd50; bus.b = 32'd8;
        step();
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL b2b_done_ignored got busy=%0b want 0", bus.busy); end
        step();
        bus.start = 1'b0;
        n_chk++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_idle_accept got busy=%0b want 1", bus.busy); end
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", cyc); end
        n_chk++; if (bus.lo_out !== 32'd6 || bus.hi_out !== 32'd2) begin n_fail++; $display("FAIL b2b_result got hi=%0d lo=%0d want hi=2 lo=6", bus.hi_out, bus.lo_out); end
        step();
    endtask

    task automatic test_reset_mid();
        int cyc; bit bd;
        bit saw_done = 0;
        start_op(2'b00, 32'h1234, 32'h10);
        for (int c = 1; c < 10; c++) step();
        rst_n = 1'b0;
        #1;
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %0b want 0", bus.busy); end
        n_chk++; if (bus.hi_out !== 32'h0 || bus.lo_out !== 32'h0) begin n_fail++; $display("FAIL rstmid_out got hi=%h lo=%h want 0 0", bus.hi_out, bus.lo_out); end
        for (int c = 0; c < 2; c++) begin
            step();
            if (bus.done !== 1'b0 || bus.hi_lo_write !== 1'b0) saw_done = 1;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (bus.done !== 1'b0 || bus.hi_lo_write !== 1'b0) saw_done = 1;
        end
        n_chk++; if (saw_done) begin n_fail++; $display("FAIL rstmid_no_done got pulse want none"); end
        n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got busy=%0b want 0", bus.busy); end
        start_op(2'b01, 32'd2, 32'd3);
        wait_done(cyc, bd);
        n_chk++; if (cyc !== 33) begin n_fail++; $display("FAIL rstmid_next_latency got %0d want 33", cyc); end
        n_chk++; if (bus.lo_out !== 32'd6 || bus.hi_out !== 32'd0) begin n_fail++; $display("FAIL rstmid_next_result got hi=%0d lo=%0d want 0 6", bus.hi_out, bus.lo_out); end
        step();
    endtask

    initial begin
        test_reset();
        test_multu_max();
        test_mult_signed();
        test_div();
        test_div_edge();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS datapath.
- Executes MULT, MULTU, DIV and DIVU from ALU operands.
- Sits directly upstream of the HI/LO register pair. It drives HI and LO result values plus a one-cycle write strobe into that pair's regWrite.
- Exposes busy so the control path can stall MFHI/MFLO until the result lands.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH split across HI and LO.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  input  WIDTH  multiplicand or dividend.
- b  input  WIDTH  multiplier or divisor.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle completion pulse.
- hi_lo_write  output  1  equal to done; drives the HI/LO pair's regWrite.
- hi_out  output  WIDTH  HI result (product[63:32] or remainder).
- lo_out  output  WIDTH  LO result (product[31:0] or quotient).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state goes to IDLE.
  - busy, done, hi_lo_write, hi_out, lo_out and all internal registers are 0.
  - Reset asserted mid-operation aborts it: no done pulse, hi_out and lo_out read 0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On an edge with start=1, latch op, a and b, then go to CALC with counter=0.
  - Exception: a DIV or DIVU with b==0 goes straight to DONE.
  - start=0 keeps the unit in IDLE.
- Operand preprocessing at the latch edge:
  - Signed ops (MULT, DIV): store magnitudes |a| and |b| and record neg_a and neg_b.
  - |0x80000000| is 0x80000000, treated as unsigned.
- CALC: exactly WIDTH cycles, one bit per edge, counter counts 0..WIDTH-1.
  - Multiply: shift-add. 64-bit accumulator; add the multiplicand when the current multiplier LSB is 1, then shift right.
  - Divide: restoring. Shift {rem, quot} left, trial-subtract the divisor, keep the result when it is non-negative, set the quotient bit.
  - At counter==WIDTH-1, go to FIX.
- FIX: one cycle of sign correction, then go to DONE.
  - MULT: negate the 64-bit product when neg_a^neg_b.
  - DIV: negate the quotient when neg_a^neg_b; negate the remainder when neg_a (remainder takes the dividend's sign).
  - Unsigned ops pass through unchanged.
- DONE: one cycle.
  - hi_out and lo_out are registered on the edge entering DONE.
  - done=1 and hi_lo_write=1 for this cycle only.
  - Next edge goes to IDLE.
- Latency:
  - Normal op: done is high in the cycle after the 33rd edge following the start-sampling edge (start edge E0, CALC E1..E32, FIX at E33 giving DONE).
  - busy is high from E0 through the DONE cycle.
  - Divide by zero: done is high in the cycle right after E0.
- Divide by zero: hi_out = a (the raw dividend), lo_out = 0xFFFFFFFF, for both DIV and DIVU.
- Signed overflow: DIV with 0x80000000 / 0xFFFFFFFF gives lo_out = 0x80000000, hi_out = 0. This falls out of the magnitude algorithm; no trap.
- start while busy (any non-IDLE state, including DONE) is ignored and not queued.
- Changes to a, b or op after the latch edge have no effect on the running operation.
- hi_out and lo_out hold the last completed result until the next DONE, or until reset.
- No back-to-back acceptance: the earliest next start is sampled in IDLE, one cycle after DONE.

Test Plan:
- MULTU, a=0xFFFFFFFF, b=0xFFFFFFFF -> done pulse exactly 33 cycles after start, hi_out=0xFFFFFFFE, lo_out=0x00000001, hi_lo_write high for 1 cycle, busy high throughout.
- MULT, a=0xFFFFFFFD (-3), b=5 -> hi_out=0xFFFFFFFF, lo_out=0xFFFFFFF1 (-15); then MULT 7*6 -> hi_out=0, lo_out=0x2A.
- DIV, a=0xFFFFFFF9 (-7), b=2 -> lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1); DIVU, a=100, b=7 -> lo_out=14, hi_out=2.
- DIVU, a=0x64, b=0 -> done one cycle after the start edge, hi_out=0x64, lo_out=0xFFFFFFFF; DIV, a=0x80000000, b=0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
- Start MULTU 3*4; pulse start with DIV 9/3 at cycle 5 and change a and b at cycle 10 -> second request ignored, result hi_out=0, lo_out=12, only one done pulse.
- Start MULT 0x1234*0x10, assert rst_n low at cycle 10 for 2 cycles -> busy=0, hi_out=lo_out=0 immediately (asynchronous), no done or hi_lo_write; a new MULTU 2*3 afterwards gives lo_out=6 normally.
